// File: rtl/sp_deserializer.sv
// ---------------------------------------------------------------------------
// sp_deserializer
//   Serial-to-parallel converter qualified by a start/valid flag (CONV) from
//   an upstream sync-pattern detector. A CONV rising edge starts a frame of
//   NWORDS words of WIDTH bits each, received MSB first with no gaps between
//   words. CONV falling mid-frame aborts the frame.
//
// Ports
//   CLK    in   1      single clock, rising edge
//   RESET  in   1      asynchronous, active-high reset
//   S_IN   in   1      serial data, MSB of each word first
//   CONV   in   1      start / frame-qualify flag
//   D_OUT  out  WIDTH  last completed word (registered)
//   VALID  out  1      one-cycle pulse: D_OUT just updated
//   BUSY   out  1      frame collection in progress
//   ERR    out  1      one-cycle pulse: frame aborted
//   WCNT   out  8      words completed in the current frame
//
// State table
//   state | meaning
//   IDLE  | waiting for a CONV rising edge
//   SHIFT | collecting bits; CONV must stay high every edge
// ---------------------------------------------------------------------------
module sp_deserializer #(
  parameter int WIDTH  = 8,
  parameter int NWORDS = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             S_IN,
  input  logic             CONV,
  output logic [WIDTH-1:0] D_OUT,
  output logic             VALID,
  output logic             BUSY,
  output logic             ERR,
  output logic [7:0]       WCNT
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
  localparam logic [7:0]    LAST_WORD = 8'(NWORDS);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             conv_q;
  // Only WIDTH-1 bits need storing: the final bit of a word comes straight
  // from S_IN on the edge that loads D_OUT.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [7:0]       wcnt_q, wcnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  logic             start;
  logic [WIDTH-1:0] shift_in;
  logic [7:0]       wcnt_inc;

  assign start    = CONV & ~conv_q;
  assign shift_in = {shreg_q, S_IN};
  assign wcnt_inc = wcnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // S_IN on the start edge is deliberately ignored.
        if (start) begin
          state_d = SHIFT;
          shreg_d = '0;
          bcnt_d  = '0;
          wcnt_d  = '0;
        end
      end
      SHIFT: begin
        if (!CONV) begin
          // Abort wins even on the last-bit edge; D_OUT and WCNT hold.
          state_d = IDLE;
          err_d   = 1'b1;
          shreg_d = '0;
          bcnt_d  = '0;
        end else if (bcnt_q == LAST_BIT) begin
          dout_d  = shift_in;
          valid_d = 1'b1;
          wcnt_d  = wcnt_inc;
          bcnt_d  = '0;
          if (wcnt_inc == LAST_WORD) state_d = IDLE;
        end else begin
          shreg_d = shift_in[WIDTH-2:0];
          bcnt_d  = bcnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      conv_q  <= 1'b0;
      shreg_q <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      conv_q  <= CONV;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign D_OUT = dout_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
  assign WCNT  = wcnt_q;
  assign BUSY  = (state_q == SHIFT);

endmodule

// File: tb/tb_sp_deserializer.sv
module tb_sp_deserializer;

  localparam int WIDTH  = 8;
  localparam int NWORDS = 2;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             S_IN;
  logic             CONV;
  logic [WIDTH-1:0] D_OUT;
  logic             VALID;
  logic             BUSY;
  logic             ERR;
  logic [7:0]       WCNT;

  sp_deserializer #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .S_IN (S_IN),
    .CONV (CONV),
    .D_OUT(D_OUT),
    .VALID(VALID),
    .BUSY (BUSY),
    .ERR  (ERR),
    .WCNT (WCNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    logic [7:0] wcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit is_err, input logic [7:0] data, input logic [7:0] wcnt);
    exp_t e;
    e.is_err = is_err;
    e.data   = data;
    e.wcnt   = wcnt;
    exp_q.push_back(e);
  endtask

  // Inputs change on the falling edge; the following rising edge samples them.
  task automatic step(input logic conv, input logic sin);
    @(negedge CLK);
    CONV = conv;
    S_IN = sin;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) step(1'b1, w[i]);
  endtask

  // Monitor: every VALID or ERR pulse must match the next queued expectation.
  always @(negedge CLK) begin
    if (VALID || ERR) begin
      chk("valid_err_exclusive", {31'd0, VALID & ERR}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got VALID=%0b ERR=%0b D_OUT=0x%0h expected none at %0t",
                 VALID, ERR, D_OUT, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_kind_err", {31'd0, ERR}, {31'd0, e.is_err});
        chk("pulse_d_out", {24'd0, D_OUT}, {24'd0, e.data});
        chk("pulse_wcnt", {24'd0, WCNT}, {24'd0, e.wcnt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    CONV  = 1'b0;
    S_IN  = 1'b0;
    #1;
    chk("reset_d_out", {24'd0, D_OUT}, 32'd0);
    chk("reset_busy",  {31'd0, BUSY},  32'd0);
    chk("reset_wcnt",  {24'd0, WCNT},  32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    step(1'b0, 1'b0);

    // Two-word frame: 0xA5 then 0x3C.
    step(1'b1, 1'b1);                   // start edge, S_IN ignored
    step(1'b1, 1'b1);                   // first bit visible BUSY check point
    chk("busy_after_start", {31'd0, BUSY}, 32'd1);
    // The step above already drove bit7 of 0xA5 (=1); send the rest.
    push(1'b0, 8'hA5, 8'd1);
    for (int i = 6; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'hA5;
      step(1'b1, w[i]);
    end
    push(1'b0, 8'h3C, 8'd2);
    send_word(8'h3C);

    // CONV held high after the frame: no restart.
    for (int n = 0; n < 10; n++) begin
      step(1'b1, 1'b1);
      chk("busy_after_frame", {31'd0, BUSY}, 32'd0);
    end
    chk("d_out_hold", {24'd0, D_OUT}, 32'h3C);

    // CONV low one cycle, then high: new frame; abort after 5 bits of 0xFF.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);                   // start
    for (int n = 0; n < 5; n++) step(1'b1, 1'b1);
    chk("busy_new_frame", {31'd0, BUSY}, 32'd1);
    push(1'b1, 8'h3C, 8'd0);
    step(1'b0, 1'b1);                   // abort edge
    step(1'b0, 1'b0);
    chk("busy_after_abort", {31'd0, BUSY}, 32'd0);
    chk("d_out_after_abort", {24'd0, D_OUT}, 32'h3C);

    // Abort exactly on the edge that would sample bit 8 of word 2.
    step(1'b1, 1'b0);                   // start
    push(1'b0, 8'h5A, 8'd1);
    send_word(8'h5A);
    for (int n = 0; n < 7; n++) step(1'b1, 1'b1);
    push(1'b1, 8'h5A, 8'd1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("busy_after_last_bit_abort", {31'd0, BUSY}, 32'd0);
    chk("d_out_after_last_bit_abort", {24'd0, D_OUT}, 32'h5A);

    // Reset mid-word (3 bits into word 2), release with CONV high.
    step(1'b1, 1'b0);                   // start
    push(1'b0, 8'hC3, 8'd1);
    send_word(8'hC3);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    #2 RESET = 1'b1;
    #1;
    chk("async_reset_d_out", {24'd0, D_OUT}, 32'd0);
    chk("async_reset_valid", {31'd0, VALID}, 32'd0);
    chk("async_reset_busy",  {31'd0, BUSY},  32'd0);
    chk("async_reset_err",   {31'd0, ERR},   32'd0);
    chk("async_reset_wcnt",  {24'd0, WCNT},  32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    CONV  = 1'b1;                       // next edge is a start
    S_IN  = 1'b1;
    push(1'b0, 8'h96, 8'd1);
    push(1'b0, 8'h01, 8'd2);
    send_word(8'h96);
    chk("busy_after_reset_start", {31'd0, BUSY}, 32'd1);
    send_word(8'h01);
    step(1'b1, 1'b0);
    chk("busy_end", {31'd0, BUSY}, 32'd0);
    chk("d_out_end", {24'd0, D_OUT}, 32'h01);

    repeat (4) step(1'b1, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
